qe_decoder: RTL and testbench
=============================

QE_DECODER -- requirements
Module: qe_decoder

Interface
REQ-001 Parameter WIDTH, default 16: counter and index-latch width, range 2..32.
REQ-002 Parameter FILT, default 2: number of consecutive equal synchronised samples needed before an input level is accepted; 0 means no filter.
REQ-003 clk  in  1  system clock; all state changes on its rising edge except reset.
REQ-004 clr  in  1  reset; clr, asynchronous, active-high.
REQ-005 i  in  1  encoder channel A, asynchronous to clk.
REQ-006 q  in  1  encoder channel B, asynchronous to clk.
REQ-007 idx  in  1  encoder index pulse, asynchronous to clk.
REQ-008 mode  in  2  counting resolution: 00 x4, 01 x2, 10 x1, 11 hold.
REQ-009 idx_clr_en  in  1  when 1, a qualified index edge zeroes count.
REQ-010 err_clr  in  1  synchronous clear of err.
REQ-011 count  out  WIDTH  signed two's-complement position.
REQ-012 dir  out  1  direction of the last counted step: 1 up, 0 down.
REQ-013 step  out  1  one-cycle pulse on every counted step.
REQ-014 wrap  out  1  one-cycle pulse when count wraps in either direction.
REQ-015 err  out  1  sticky illegal-transition flag.
REQ-016 idx_pos  out  WIDTH  count value captured at the last qualified index edge.

Function
REQ-017 i, q and idx SHALL each pass through a 2-flop synchroniser; no other logic SHALL sample the raw pins.
REQ-018 Each synchronised channel SHALL update its filtered level only after FILT+1 consecutive identical samples; with FILT=0 the filtered level SHALL equal the synchronised level.
REQ-019 The decoder SHALL register the previous filtered pair AB=(i,q) and compare it each cycle with the current pair.
REQ-020 The forward (+1) sequence SHALL be 00->10->11->01->00, i.e. A leads B; the reverse sequence SHALL be -1.
REQ-021 Only one channel changing SHALL be a legal step; both changing in one cycle SHALL set err, leave count unchanged, and update the previous pair.
REQ-022 x4 mode SHALL count every legal step.
REQ-023 x2 mode SHALL count only legal steps where A changed.
REQ-024 x1 mode SHALL count only A rising: +1 when B=0, -1 when B=1.
REQ-025 Hold mode SHALL not count but SHALL keep tracking the previous pair and detecting errors.
REQ-026 A counted step SHALL update count, dir and step in the same clock edge.
REQ-027 With FILT=0, latency from a pin change to count SHALL be 3 rising edges; each filter sample SHALL add 1 edge.
REQ-028 Count SHALL wrap modulo 2^WIDTH: max+1 gives min, and min-1 gives max.
REQ-029 On a wrap, wrap SHALL pulse for exactly that cycle.
REQ-030 A rising edge of filtered idx SHALL load idx_pos with the count value before that cycle's update.
REQ-031 If idx_clr_en=1 on that same edge, count SHALL become 0; this clear SHALL override a coincident step, and step and wrap SHALL stay 0 that cycle.
REQ-032 err_clr=1 SHALL clear err; a coincident illegal transition SHALL win, leaving err at 1.
REQ-033 A mode change SHALL take effect on the next cycle and SHALL not cause a count.

Reset
REQ-034 While clr=1: count, idx_pos, dir, step, wrap, err, synchronisers, filters and the previous pair SHALL all be 0.
REQ-035 The first accepted filtered pair after clr deasserts SHALL only initialise the previous pair, without counting or flagging err, even if it is 11.
REQ-036 Asserting clr mid-operation SHALL abort any in-progress filter qualification.

Verification
REQ-037 x4, FILT=0, from 00: drive 10, 11, 01, 00, each held 5 cycles -> count=4, dir=1, four step pulses.
REQ-038 x1: one full reverse cycle 00->01->11->10->00 -> count=-1 (16'hFFFF), dir=0, one step pulse.
REQ-039 WIDTH=16, count at 16'h7FFF, one forward step -> count=16'h8000, wrap pulses once; then one reverse step -> 16'h7FFF, wrap pulses again.
REQ-040 i and q toggled in the same cycle (00->11) -> err=1, count unchanged; err_clr pulse -> err=0.
REQ-041 FILT=2, 2-cycle glitch on i -> no count; then a 3-cycle level change -> exactly one count.
REQ-042 count=37, idx_clr_en=1, idx rises coincident with a forward step -> idx_pos=37, count=0, no step pulse.

Source files
------------

// File: rtl/qe_decoder.sv
// Quadrature encoder decoder: synchronised, glitch-filtered A/B/index inputs driving a signed position counter.
// Pin-to-count latency is 3 edges unfiltered, plus one edge per required filter sample.
module qe_decoder #(
  parameter int WIDTH = 16,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i,
  input  logic             q,
  input  logic             idx,
  input  logic [1:0]       mode,
  input  logic             idx_clr_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic [WIDTH-1:0] idx_pos
);

  localparam int WARM = (FILT == 0) ? 3 : FILT + 4;

  logic [2:0]       r_s1, r_s2;
  logic [2:0]       w_flt;
  logic [7:0]       r_warm;
  logic [1:0]       r_prev;
  logic [1:0]       r_mode;
  logic             r_idx_prev;
  logic [WIDTH-1:0] r_count, r_idx_pos;
  logic             r_dir, r_step, r_wrap, r_err;

  // channel order: bit 0 = A (i), bit 1 = B (q), bit 2 = index
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {idx, q, i};
      r_s2 <= r_s1;
    end
  end

  generate
    if (FILT == 0) begin : g_nofilt
      assign w_flt = r_s2;
    end else begin : g_filt
      localparam int CW = $clog2(FILT + 1);
      logic [2:0]    r_flt;
      logic [CW-1:0] r_cnt [3];
      // a new level is accepted on its FILT+1-th consecutive sample
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          r_flt <= '0;
          for (int k = 0; k < 3; k++) r_cnt[k] <= '0;
        end else begin
          for (int k = 0; k < 3; k++) begin
            if (r_s2[k] == r_flt[k]) begin
              r_cnt[k] <= '0;
            end else if (r_cnt[k] == CW'(FILT)) begin
              r_flt[k] <= r_s2[k];
              r_cnt[k] <= '0;
            end else begin
              r_cnt[k] <= r_cnt[k] + CW'(1);
            end
          end
        end
      end
      assign w_flt = r_flt;
    end
  endgenerate

  logic             w_rdy, w_a, w_b, w_da, w_db, w_bad, w_up, w_cnt_en, w_idx_rise;
  logic [WIDTH-1:0] w_next, w_max, w_min;

  // until the pipeline has filled, the previous pair only tracks the input
  assign w_rdy      = (r_warm == 8'(WARM));
  assign w_a        = w_flt[0];
  assign w_b        = w_flt[1];
  assign w_da       = w_a ^ r_prev[1];
  assign w_db       = w_b ^ r_prev[0];
  assign w_bad      = w_da & w_db;
  assign w_up       = w_da ? (w_a ^ w_b) : ~(w_a ^ w_b);
  assign w_idx_rise = w_rdy & w_flt[2] & ~r_idx_prev;
  assign w_max      = {1'b0, {(WIDTH-1){1'b1}}};
  assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_next     = w_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);

  always_comb begin
    w_cnt_en = 1'b0;
    if (w_rdy && !w_bad && (w_da || w_db)) begin
      case (r_mode)
        2'b00:   w_cnt_en = 1'b1;
        2'b01:   w_cnt_en = w_da;
        2'b10:   w_cnt_en = w_da & w_a;
        default: w_cnt_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_warm     <= '0;
      r_prev     <= '0;
      r_mode     <= '0;
      r_idx_prev <= 1'b0;
      r_count    <= '0;
      r_idx_pos  <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mode     <= mode;
      r_prev     <= {w_a, w_b};
      r_idx_prev <= w_flt[2];
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      if (!w_rdy) r_warm <= r_warm + 8'd1;
      if (w_rdy && w_bad) r_err <= 1'b1;
      else if (err_clr)   r_err <= 1'b0;
      if (w_idx_rise) r_idx_pos <= r_count;
      // index clear beats a coincident step and suppresses its pulses
      if (w_idx_rise && idx_clr_en) begin
        r_count <= '0;
      end else if (w_cnt_en) begin
        r_count <= w_next;
        r_dir   <= w_up;
        r_step  <= 1'b1;
        r_wrap  <= w_up ? (r_count == w_max) : (r_count == w_min);
      end
    end
  end

  assign count   = r_count;
  assign idx_pos = r_idx_pos;
  assign dir     = r_dir;
  assign step    = r_step;
  assign wrap    = r_wrap;
  assign err     = r_err;

endmodule

// File: tb/tb_qe_decoder.sv
// Scoreboarded bench for qe_decoder: unfiltered instance for counting/index/error, filtered instance for glitch rejection.
module tb_qe_decoder;

  logic        clk = 1'b0;
  logic        clr;
  logic        i, q, idx, idx_clr_en, err_clr;
  logic [1:0]  mode;
  logic [15:0] count, idx_pos;
  logic        dir, step, wrap, err;

  logic        i2, q2, idx2;
  logic [1:0]  mode2;
  logic [15:0] count2, idx_pos2;
  logic        dir2, step2, wrap2, err2;

  always #5 clk = ~clk;

  qe_decoder #(.WIDTH(16), .FILT(0)) u0 (
    .clk(clk), .clr(clr), .i(i), .q(q), .idx(idx), .mode(mode),
    .idx_clr_en(idx_clr_en), .err_clr(err_clr), .count(count), .dir(dir),
    .step(step), .wrap(wrap), .err(err), .idx_pos(idx_pos)
  );

  qe_decoder #(.WIDTH(16), .FILT(2)) u2 (
    .clk(clk), .clr(clr), .i(i2), .q(q2), .idx(idx2), .mode(mode2),
    .idx_clr_en(1'b0), .err_clr(1'b0), .count(count2), .dir(dir2),
    .step(step2), .wrap(wrap2), .err(err2), .idx_pos(idx_pos2)
  );

  typedef struct packed {
    logic [15:0] c;
    logic        d;
    logic        w;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wrap  = 0;
  int          n_step2 = 0;
  logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          s;
  logic [15:0] exp_c;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    i = ab[1];
    q = ab[0];
  endtask

  task automatic push(input logic [15:0] c, input logic d, input logic w);
    exp_t e;
    e.c = c;
    e.d = d;
    e.w = w;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: every step pulse is matched against the next scoreboard entry
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (step) begin
      n_tests++;
      if (wrap) n_wrap++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL step_unexpected: got count=%h dir=%b wrap=%b, expected no step", count, dir, wrap);
      end else begin
        e = sb.pop_front();
        if (count !== e.c || dir !== e.d || wrap !== e.w) begin
          n_fail++;
          $display("FAIL step_cmp: got count=%h dir=%b wrap=%b, expected count=%h dir=%b wrap=%b",
                   count, dir, wrap, e.c, e.d, e.w);
        end
      end
    end else if (wrap) begin
      n_tests++;
      n_fail++;
      $display("FAIL wrap_without_step: got wrap=1, expected 0");
    end
    if (step2) n_step2++;
  end

  initial begin
    clr = 1'b1; i = 1'b1; q = 1'b1; idx = 1'b0; mode = 2'b11;
    idx_clr_en = 1'b0; err_clr = 1'b0;
    i2 = 1'b0; q2 = 1'b0; idx2 = 1'b0; mode2 = 2'b00;
    cyc(3);
    chk("rst_count", count, 0);
    chk("rst_idx_pos", idx_pos, 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", step, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_err", err, 0);

    // pins at 11 out of reset: only initialises the previous pair
    clr = 1'b0;
    cyc(12);
    chk("init_err", err, 0);
    chk("init_count", count, 0);
    set_ab(2'b01); cyc(5);
    set_ab(2'b00); cyc(5);
    chk("hold_err", err, 0);
    chk("hold_count", count, 0);

    // x4 forward cycle
    mode = 2'b00; cyc(3);
    for (int k = 1; k <= 4; k++) begin
      set_ab(seq[k % 4]);
      push(16'(k), 1'b1, 1'b0);
      cyc(5);
    end
    chk("x4_count", count, 4);
    chk("x4_dir", dir, 1);

    // index clear with no step
    idx_clr_en = 1'b1; idx = 1'b1; cyc(6);
    chk("idx1_pos", idx_pos, 4);
    chk("idx1_count", count, 0);
    idx = 1'b0; cyc(5);

    // x1 reverse cycle: one down count on A rising with B=1
    mode = 2'b10; cyc(3);
    set_ab(2'b01); cyc(5);
    set_ab(2'b11); push(16'hFFFF, 1'b0, 1'b0); cyc(5);
    set_ab(2'b10); cyc(5);
    set_ab(2'b00); cyc(5);
    chk("x1_count", count, 16'hFFFF);
    chk("x1_dir", dir, 0);

    // illegal double change, then err_clr
    mode = 2'b00; cyc(3);
    set_ab(2'b11); cyc(5);
    chk("bad_err", err, 1);
    chk("bad_count", count, 16'hFFFF);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0; cyc(2);
    chk("errclr_err", err, 0);
    set_ab(2'b01); push(16'h0000, 1'b1, 1'b0); cyc(5);
    set_ab(2'b00); push(16'h0001, 1'b1, 1'b0); cyc(5);

    // run forward one step per cycle up through the signed maximum
    s = 0;
    exp_c = 16'h0001;
    for (int k = 0; k < 32767; k++) begin
      s = (s + 1) % 4;
      set_ab(seq[s]);
      push(exp_c + 16'd1, 1'b1, exp_c == 16'h7FFF);
      exp_c = exp_c + 16'd1;
      cyc(1);
    end
    cyc(5);
    chk("wrap_up_count", count, 16'h8000);
    s = (s + 3) % 4;
    set_ab(seq[s]);
    push(16'h7FFF, 1'b0, 1'b1);
    cyc(5);
    chk("wrap_dn_count", count, 16'h7FFF);
    chk("wrap_pulses", n_wrap, 2);

    // zero, advance to 37, then index edge coincident with a forward step
    idx = 1'b1; cyc(6);
    chk("idx2_pos", idx_pos, 16'h7FFF);
    chk("idx2_count", count, 0);
    idx = 1'b0; cyc(5);
    for (int k = 1; k <= 37; k++) begin
      s = (s + 1) % 4;
      set_ab(seq[s]);
      push(16'(k), 1'b1, 1'b0);
      cyc(1);
    end
    cyc(5);
    chk("pre_idx_count", count, 37);
    s = (s + 1) % 4;
    set_ab(seq[s]);
    idx = 1'b1;
    cyc(6);
    chk("idx3_pos", idx_pos, 37);
    chk("idx3_count", count, 0);
    idx = 1'b0; cyc(5);

    // filtered instance: 2-cycle glitch rejected, 3-cycle level accepted
    i2 = 1'b1; cyc(2); i2 = 1'b0; cyc(10);
    chk("glitch_steps", n_step2, 0);
    chk("glitch_count", count2, 0);
    i2 = 1'b1; cyc(3); cyc(10);
    chk("filt_steps", n_step2, 1);
    chk("filt_count", count2, 1);

    cyc(5);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
